// File: rtl/bitonic_stream_unloader_pkg.sv
// Shared definitions for the bitonic sorter back end: direction codes,
// the unloader state type and the lane-index width helper.
package bitonic_pkg;

    localparam logic DIR_ASC  = 1'b1;
    localparam logic DIR_DESC = 1'b0;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } unload_state_t;

    // A single-lane vector still needs a one-bit index port.
    function automatic int lane_index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bitonic_stream_unloader_lane_mux.sv
// N:1 selector that picks one W-bit lane out of a flat N*W vector.
module bitonic_lane_mux
    import bitonic_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 8,
    localparam int IW = lane_index_width(N)
) (
    input  logic [N*W-1:0] lanes,
    input  logic [IW-1:0]  sel,
    output logic [W-1:0]   y
);

    always_comb begin
        y = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == IW'(i)) begin
                y = lanes[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/bitonic_stream_unloader.sv
// Parallel-in / serial-out unloader for the bitonic sorting network.
// Optional order checker enabled by defining BITONIC_UNLOAD_CHECK_EN.
module bitonic_stream_unloader
    import bitonic_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 8,
    localparam int IW = lane_index_width(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           direction,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [IW-1:0]  out_index,
    output logic           out_last,
    output logic           sort_err
);

    localparam logic [IW-1:0] LAST_LANE = IW'(N - 1);

    unload_state_t  state;
    logic [IW-1:0]  counter;
    logic [N*W-1:0] hold;
    logic [W-1:0]   lane_data;
    logic           drain;
    logic           out_xfer;
    logic           take;

    bitonic_lane_mux #(
        .W (W),
        .N (N)
    ) u_lane_mux (
        .lanes (hold),
        .sel   (counter),
        .y     (lane_data)
    );

    assign drain     = (state == DRAIN);
    assign out_valid = drain;
    assign out_last  = drain && (counter == LAST_LANE);
    assign out_index = counter;
    assign out_data  = drain ? lane_data : '0;
    assign out_xfer  = drain && out_ready;
    // Accepting on the last-lane handshake is what removes the inter-vector bubble.
    assign in_ready  = !drain || (out_last && out_ready);
    assign take      = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            counter <= '0;
            hold    <= '0;
        end else begin
            if (take) begin
                hold <= in_data;
            end
            if (out_xfer) begin
                counter <= out_last ? '0 : counter + 1'b1;
            end else if (take) begin
                counter <= '0;
            end
            if (state == IDLE) begin
                if (take) begin
                    state <= DRAIN;
                end
            end else if (out_xfer && out_last && !in_valid) begin
                state <= IDLE;
            end
        end
    end

`ifdef BITONIC_UNLOAD_CHECK_EN
    logic         dir;
    logic [W-1:0] prev;
    logic         err;

    // Lane 0 opens a new vector, so it is never compared against the last one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir  <= DIR_ASC;
            prev <= '0;
            err  <= 1'b0;
        end else begin
            if (take) begin
                dir <= direction;
            end
            if (out_xfer) begin
                prev <= lane_data;
                if ((counter != '0) &&
                    (((dir == DIR_ASC) && (lane_data < prev)) ||
                     ((dir == DIR_DESC) && (lane_data > prev)))) begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign sort_err = err;
`else
    logic unused_direction;
    assign unused_direction = direction;
    assign sort_err = 1'b0;
`endif

endmodule
